life_grid_engine: RTL and testbench

Parametrised Conway's Game of Life engine with a ROWS×COLS cell grid held in flops. It loads a pattern serially, advances one generation per step command with all cells updated in parallel, and streams the grid back out serially. It replaces the fixed 5×5 engine as the core of the tiny game-of-life design. It adds explicit commands, a generation counter, a stability/extinction status and an optional toroidal wrap.

---
 rtl/life_grid_engine.sv | 142 ++++++++++++++
 tb/tb_life_grid_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_engine.sv
// life_grid_engine: Conway's Game of Life on a ROWS x COLS grid held in flops.
//   A pattern is loaded serially, one generation is computed per step command
//   with every cell updated in parallel, and the grid is streamed back serially.
//   Optional feature macro: LIFE_TORUS_EN (defined -> neighbours wrap around the
//   grid edges; undefined -> off-grid neighbours are dead).
// Ports:
//   clock, reset           : single clock, synchronous active-high reset
//   cmd_load/step/dump     : commands, sampled only in IDLE (load > step > dump)
//   in_bit, in_valid       : serial load data and qualifier
//   out_bit, out_valid     : serial dump data, valid exactly while dumping
//   busy                   : engine not idle
//   gen_count              : generations stepped since reset / last load
//   stable                 : last step changed no cell
//   extinct                : grid is all dead
module life_grid_engine #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int GEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_load,
  input  logic             cmd_step,
  input  logic             cmd_dump,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             extinct
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, DUMP} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d, grid_nxt;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;

  // Next-generation grid. Neighbour slot d (0..8) covers offsets
  // (d/3-1, d%3-1); slot 4 is the cell itself and is tied off.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [8:0] nb;
      logic [3:0] cnt;
      for (genvar d = 0; d < 9; d++) begin : g_nb
        localparam int RR = r + d / 3 - 1;
        localparam int CC = c + d % 3 - 1;
        if (d == 4) begin : g_self
          assign nb[d] = 1'b0;
        end else begin : g_other
`ifdef LIFE_TORUS_EN
          assign nb[d] = grid_q[((RR + ROWS) % ROWS) * COLS + ((CC + COLS) % COLS)];
`else
          if (RR < 0 || RR >= ROWS || CC < 0 || CC >= COLS) begin : g_off
            assign nb[d] = 1'b0;
          end else begin : g_on
            assign nb[d] = grid_q[RR * COLS + CC];
          end
`endif
        end
      end
      always_comb begin
        cnt = '0;
        for (int i = 0; i < 9; i++) cnt = cnt + {3'b000, nb[i]};
      end
      assign grid_nxt[r*COLS+c] = (cnt == 4'd3) | (grid_q[r*COLS+c] & (cnt == 4'd2));
    end
  end

  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    idx_d    = idx_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    case (state_q)
      IDLE: begin
        if (cmd_load)      state_d = LOAD;
        else if (cmd_step) state_d = STEP;
        else if (cmd_dump) state_d = DUMP;
      end
      LOAD: begin
        if (in_valid) begin
          grid_d[idx_q] = in_bit;
          if (idx_q == LAST) begin
            idx_d    = '0;
            gen_d    = '0;
            stable_d = 1'b0;
            state_d  = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      STEP: begin
        grid_d   = grid_nxt;
        gen_d    = gen_q + 1'b1;
        stable_d = (grid_nxt == grid_q);
        state_d  = IDLE;
      end
      DUMP: begin
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grid_q   <= '0;
      idx_q    <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      idx_q    <= idx_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
    end
  end

  assign out_valid = (state_q == DUMP);
  assign out_bit   = out_valid & grid_q[idx_q];
  assign busy      = (state_q != IDLE);
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign extinct   = ~|grid_q;
endmodule

// File: tb/tb_life_grid_engine.sv
module tb_life_grid_engine;
  logic clock = 1'b0;
  logic reset, cmd_load, cmd_step, cmd_dump, in_bit, in_valid;
  logic out_bit, out_valid, busy, stable, extinct;
  logic [7:0] gen_count;
  logic out_bit2, out_valid2, busy2, stable2, extinct2;
  logic [1:0] gen_count2;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  life_grid_engine #(.ROWS(5), .COLS(5), .GEN_W(8)) dut (
    .clock(clock), .reset(reset), .cmd_load(cmd_load), .cmd_step(cmd_step),
    .cmd_dump(cmd_dump), .in_bit(in_bit), .in_valid(in_valid),
    .out_bit(out_bit), .out_valid(out_valid), .busy(busy),
    .gen_count(gen_count), .stable(stable), .extinct(extinct));

  // Narrow-counter instance sharing all inputs, used for the wrap check.
  life_grid_engine #(.ROWS(5), .COLS(5), .GEN_W(2)) dut2 (
    .clock(clock), .reset(reset), .cmd_load(cmd_load), .cmd_step(cmd_step),
    .cmd_dump(cmd_dump), .in_bit(in_bit), .in_valid(in_valid),
    .out_bit(out_bit2), .out_valid(out_valid2), .busy(busy2),
    .gen_count(gen_count2), .stable(stable2), .extinct(extinct2));

  localparam logic [24:0] BLINK_H = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
  localparam logic [24:0] BLINK_V = (25'd1 << 7) | (25'd1 << 12) | (25'd1 << 17);
  localparam logic [24:0] BLOCK   = (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 11) | (25'd1 << 12);
  localparam logic [24:0] SINGLE  = (25'd1 << 12);
  localparam logic [24:0] GLIDER  = (25'd1 << 1) | (25'd1 << 7) | (25'd1 << 10) |
                                    (25'd1 << 11) | (25'd1 << 12);
  localparam logic [24:0] CORNER  = (25'd1 << 18) | (25'd1 << 19) | (25'd1 << 23) | (25'd1 << 24);

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic do_load(input logic [24:0] pat);
    @(negedge clock) cmd_load = 1'b1;
    @(negedge clock) cmd_load = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 25; k++) begin
      in_bit = pat[k];
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic do_step();
    @(negedge clock) cmd_step = 1'b1;
    @(negedge clock) cmd_step = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_dump(output logic [24:0] got, output int nvalid);
    got = '0;
    nvalid = 0;
    @(negedge clock) cmd_dump = 1'b1;
    @(negedge clock) cmd_dump = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        if (nvalid < 25) got[nvalid] = out_bit;
        nvalid++;
      end else if (nvalid > 0) begin
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (out_bit !== 1'b0)   begin failures++; $display("FAIL rst_out_bit got=%b exp=0", out_bit); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (gen_count !== 8'd0) begin failures++; $display("FAIL rst_gen got=%0d exp=0", gen_count); end
    checks++; if (stable !== 1'b0)    begin failures++; $display("FAIL rst_stable got=%b exp=0", stable); end
    checks++; if (extinct !== 1'b1)   begin failures++; $display("FAIL rst_extinct got=%b exp=1", extinct); end
  endtask

  task automatic test_blinker();
    logic [24:0] got;
    int n;
    do_load(BLINK_H);
    @(negedge clock) cmd_step = 1'b1;
    @(negedge clock) cmd_step = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL step_busy got=%b exp=1", busy); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL step_busy_fall got=%b exp=0", busy); end
    checks++; if (gen_count !== 8'd1) begin failures++; $display("FAIL blink_gen1 got=%0d exp=1", gen_count); end
    checks++; if (stable !== 1'b0) begin failures++; $display("FAIL blink_stable got=%b exp=0", stable); end
    do_dump(got, n);
    checks++; if (got !== BLINK_V) begin failures++; $display("FAIL blink_v got=%h exp=%h", got, BLINK_V); end
    checks++; if (n !== 25) begin failures++; $display("FAIL blink_nvalid got=%0d exp=25", n); end
    do_step();
    checks++; if (gen_count !== 8'd2) begin failures++; $display("FAIL blink_gen2 got=%0d exp=2", gen_count); end
    do_dump(got, n);
    checks++; if (got !== BLINK_H) begin failures++; $display("FAIL blink_h got=%h exp=%h", got, BLINK_H); end
  endtask

  task automatic test_block_extinct();
    logic [24:0] got;
    int n;
    do_load(BLOCK);
    checks++; if (gen_count !== 8'd0) begin failures++; $display("FAIL load_gen_clear got=%0d exp=0", gen_count); end
    do_step();
    checks++; if (stable !== 1'b1)  begin failures++; $display("FAIL block_stable got=%b exp=1", stable); end
    checks++; if (extinct !== 1'b0) begin failures++; $display("FAIL block_extinct got=%b exp=0", extinct); end
    do_dump(got, n);
    checks++; if (got !== BLOCK) begin failures++; $display("FAIL block_grid got=%h exp=%h", got, BLOCK); end
    do_load(SINGLE);
    checks++; if (stable !== 1'b0) begin failures++; $display("FAIL load_stable_clear got=%b exp=0", stable); end
    do_step();
    checks++; if (extinct !== 1'b1) begin failures++; $display("FAIL single_extinct got=%b exp=1", extinct); end
    checks++; if (stable !== 1'b0)  begin failures++; $display("FAIL single_stable got=%b exp=0", stable); end
  endtask

  task automatic test_glider();
    logic [24:0] got, exp;
    int n;
`ifdef LIFE_TORUS_EN
    exp = GLIDER;
`else
    exp = CORNER;
`endif
    do_load(GLIDER);
    repeat (20) do_step();
    checks++; if (gen_count !== 8'd20) begin failures++; $display("FAIL glider_gen got=%0d exp=20", gen_count); end
    checks++; if (gen_count2 !== 2'd0) begin failures++; $display("FAIL glider_gen2 got=%0d exp=0", gen_count2); end
    do_dump(got, n);
    checks++; if (got !== exp) begin failures++; $display("FAIL glider_grid got=%h exp=%h", got, exp); end
  endtask

  task automatic test_toggle_load();
    logic [24:0] pat, got;
    int n, k;
    pat = 25'h1A53C9F;
    k = 0;
    @(negedge clock) begin cmd_load = 1'b1; in_bit = 1'b1; end
    @(negedge clock) cmd_load = 1'b0;
    for (int c = 0; c < 50; c++) begin
      in_valid = (c % 2 == 0);
      // Hold cycles drive the inverted bit so a spurious capture shows up.
      in_bit = in_valid ? pat[k] : ~pat[k];
      if (c == 20) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy); end
      end
      @(negedge clock);
      if (in_valid) k++;
    end
    in_valid = 1'b0;
    in_bit = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL load_done got=%b exp=0", busy); end
    do_dump(got, n);
    checks++; if (got !== pat) begin failures++; $display("FAIL toggle_grid got=%h exp=%h", got, pat); end
    checks++; if (n !== 25) begin failures++; $display("FAIL toggle_nvalid got=%0d exp=25", n); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int n;
    do_load(BLOCK);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock) cmd_step = 1'b1;
      @(negedge clock) cmd_step = 1'b0;
      @(negedge clock);
      checks++; if (gen_count2 !== seq2[i]) begin failures++; $display("FAIL wrap_gen2[%0d] got=%0d exp=%0d", i, gen_count2, seq2[i]); end
    end
    checks++; if (gen_count !== 8'd5) begin failures++; $display("FAIL wrap_gen8 got=%0d exp=5", gen_count); end
    // Commands held high during a dump must neither step nor re-dump.
    n = 0;
    @(negedge clock) cmd_dump = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cmd_step = (i < 20);
      cmd_dump = (i < 20);
      if (out_valid) n++;
    end
    checks++; if (n !== 25) begin failures++; $display("FAIL busy_dump_len got=%0d exp=25", n); end
    checks++; if (gen_count !== 8'd5) begin failures++; $display("FAIL busy_no_step got=%0d exp=5", gen_count); end
    // A dump request during the step cycle is ignored.
    @(negedge clock) cmd_step = 1'b1;
    @(negedge clock) begin cmd_step = 1'b0; cmd_dump = 1'b1; end
    @(negedge clock) cmd_dump = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) n++;
      @(negedge clock);
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL step_no_dump got=%0d exp=0", n); end
    checks++; if (gen_count !== 8'd6) begin failures++; $display("FAIL step_once got=%0d exp=6", gen_count); end
  endtask

  task automatic test_reset_mid_dump();
    logic [24:0] got;
    int n;
    do_load(BLINK_H);
    do_step();
    @(negedge clock) cmd_dump = 1'b1;
    @(negedge clock) cmd_dump = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (gen_count !== 8'd0) begin failures++; $display("FAIL mid_rst_gen got=%0d exp=0", gen_count); end
    checks++; if (extinct !== 1'b1)   begin failures++; $display("FAIL mid_rst_extinct got=%b exp=1", extinct); end
    do_dump(got, n);
    checks++; if (got !== 25'd0) begin failures++; $display("FAIL mid_rst_grid got=%h exp=0", got); end
    checks++; if (n !== 25) begin failures++; $display("FAIL mid_rst_nvalid got=%0d exp=25", n); end
  endtask

  initial begin
    reset = 1'b1; cmd_load = 1'b0; cmd_step = 1'b0; cmd_dump = 1'b0;
    in_bit = 1'b0; in_valid = 1'b0;
    test_reset();
    test_blinker();
    test_block_extinct();
    test_glider();
    test_toggle_load();
    test_back_to_back();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
